// File: rtl/cnn_window_gen.sv
// Sliding K x K window generator over a raster pixel stream.
// Holds K-1 line buffers plus a K x K shift window and emits strided windows over valid/ready.
module cnn_window_gen #(
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_vld,
  input  logic [PIX_W-1:0]       in_data,
  output logic                   in_rdy,
  output logic                   out_vld,
  output logic [K*K*PIX_W-1:0]   out_win,
  input  logic                   out_rdy,
  output logic                   frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned WW = K * K * PIX_W;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PW-1:0]    col_ph;
  logic [PW-1:0]    row_ph;
  logic [PIX_W-1:0] lb      [K-1][IMG_W];
  logic [PIX_W-1:0] win     [K][K];
  logic [PIX_W-1:0] win_nxt [K][K];
  logic [PIX_W-1:0] col_new [K];
  logic [WW-1:0]    win_flat;
  logic             in_xfer;
  logic             out_xfer;
  logic             qualify;
  logic             col_last;
  logic             row_last;

  assign in_rdy   = rst_n && !clr && (!out_vld || out_rdy);
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // Phases are zero exactly on stride-aligned rows/columns once the window is full.
  assign qualify  = (row >= RW'(K - 1)) && (col >= CW'(K - 1)) &&
                    (row_ph == '0) && (col_ph == '0);

  // Next window: shift columns left, new right column from line buffers (oldest first) plus input.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_new[r] = lb[r][col];
    col_new[K-1] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = col_new[r];
    end
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) win_flat[(r*K+c)*PIX_W +: PIX_W] = win_nxt[r][c];
    end
  end

  // Pixel storage; contents need no reset since windows only use current-frame data.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      for (int i = 0; i < int'(K) - 2; i++) lb[i][col] <= lb[i+1][col];
      lb[K-2][col] <= in_data;
      win          <= win_nxt;
    end
  end

  // Raster counters, stride phases and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      out_vld    <= 1'b0;
      out_win    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_xfer) begin
        if (col_last) begin
          col    <= '0;
          col_ph <= '0;
          if (row_last) begin
            row        <= '0;
            row_ph     <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
            if (row >= RW'(K - 1))
              row_ph <= (row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col >= CW'(K - 1))
            col_ph <= (col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
        end
      end
      if (in_xfer && qualify) begin
        out_vld <= 1'b1;
        out_win <= win_flat;
      end else if (out_xfer) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Randomised bench for cnn_window_gen: three parameterisations share one driver and a frame-array reference model.
module tb_cnn_window_gen;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clr     = 1'b0;
  logic       in_vld  = 1'b0;
  logic       out_rdy = 1'b1;
  logic [7:0] in_data = 8'd0;
  int         sel     = 0;
  int cw = 4, ch = 4, ck = 3, cs = 1, cpw = 8;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, fd_a, fd_b, fd_c;
  logic [71:0] ow_a;
  logic [8:0]  ow_b;
  logic [15:0] ow_c;

  cnn_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld && (sel == 0)), .in_data(in_data),
    .in_rdy(rdy_a), .out_vld(vld_a), .out_win(ow_a), .out_rdy(out_rdy), .frame_done(fd_a));

  cnn_window_gen #(.PIX_W(1), .IMG_W(28), .IMG_H(28), .K(3), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld && (sel == 1)), .in_data(in_data[0:0]),
    .in_rdy(rdy_b), .out_vld(vld_b), .out_win(ow_b), .out_rdy(out_rdy), .frame_done(fd_b));

  cnn_window_gen #(.PIX_W(4), .IMG_W(7), .IMG_H(5), .K(2), .STRIDE(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld && (sel == 2)), .in_data(in_data[3:0]),
    .in_rdy(rdy_c), .out_vld(vld_c), .out_win(ow_c), .out_rdy(out_rdy), .frame_done(fd_c));

  logic        in_rdy_m, out_vld_m, fd_m;
  logic [71:0] win_m;

  always_comb begin
    case (sel)
      0:       begin in_rdy_m = rdy_a; out_vld_m = vld_a; fd_m = fd_a; win_m = ow_a;       end
      1:       begin in_rdy_m = rdy_b; out_vld_m = vld_b; fd_m = fd_b; win_m = 72'(ow_b); end
      default: begin in_rdy_m = rdy_c; out_vld_m = vld_c; fd_m = fd_c; win_m = 72'(ow_c); end
    endcase
  end

  // Reference model state: the current frame as a 2-D array plus expected-window FIFO.
  logic [7:0]  img [32][32];
  logic [71:0] exp_q [$];
  int          mr = 0, mc = 0, acc_cnt = 0, first_idx = -1, win_cnt = 0;
  int          fd_cnt = 0, fd_last = 0, fd_prev = 0, cyc_n = 0;
  logic        seen_first = 1'b0, fd_pend = 1'b0, last_acc = 1'b0;
  logic        prev_rs = 1'b0, prev_hard = 1'b0, prev_stall = 1'b0;
  logic [71:0] prev_win = '0, first_win = '0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pmask();
    return 8'((1 << cpw) - 1);
  endfunction

  function automatic int nwin(input int w, input int h, input int k, input int s);
    return ((w - k) / s + 1) * ((h - k) / s + 1);
  endfunction

  // Called once per negedge: checks outputs, then folds the upcoming edge's transfers into the model.
  task automatic mon_step();
    logic        rs;
    logic [71:0] e;
    cyc_n++;
    rs = !rst_n || clr;
    check_eq("in_rdy", 72'(in_rdy_m), 72'(rst_n && !clr && (!out_vld_m || out_rdy)));
    if (prev_rs) begin
      check_eq("rst_out_vld", 72'(out_vld_m), 72'(0));
      check_eq("rst_frame_done", 72'(fd_m), 72'(0));
    end else begin
      check_eq("frame_done", 72'(fd_m), 72'(fd_pend));
    end
    if (prev_hard) check_eq("rst_out_win", win_m, 72'(0));
    if (prev_stall && !prev_rs) begin
      check_eq("stall_vld", 72'(out_vld_m), 72'(1));
      check_eq("stall_win", win_m, prev_win);
    end
    if (fd_m) begin fd_cnt++; fd_prev = fd_last; fd_last = cyc_n; end
    if (out_vld_m && !seen_first) begin
      seen_first = 1'b1; first_idx = acc_cnt - 1; first_win = win_m;
    end
    if (out_vld_m && out_rdy) begin
      win_cnt++;
      check_eq("win_expected", 72'(exp_q.size() != 0), 72'(1));
      if (exp_q.size() != 0) check_eq("win", win_m, exp_q.pop_front());
    end
    fd_pend  = 1'b0;
    last_acc = 1'b0;
    if (rs) begin
      mr = 0; mc = 0; acc_cnt = 0; seen_first = 1'b0;
      exp_q.delete();
    end else if (in_vld && in_rdy_m) begin
      last_acc = 1'b1;
      img[mr][mc] = in_data & pmask();
      acc_cnt++;
      if (mr >= ck - 1 && mc >= ck - 1 && (mr - (ck - 1)) % cs == 0 && (mc - (ck - 1)) % cs == 0) begin
        e = '0;
        for (int i = 0; i < ck; i++)
          for (int j = 0; j < ck; j++)
            e = e | (72'(img[mr-ck+1+i][mc-ck+1+j]) << ((i * ck + j) * cpw));
        exp_q.push_back(e);
      end
      if (mc == cw - 1) begin
        mc = 0;
        if (mr == ch - 1) begin mr = 0; fd_pend = 1'b1; end
        else mr++;
      end else begin
        mc++;
      end
    end
    prev_rs    = rs;
    prev_hard  = !rst_n;
    prev_stall = out_vld_m && !out_rdy;
    prev_win   = win_m;
  endtask

  task automatic cyc();
    @(negedge clk); mon_step();
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input int vld_pct, input int rdy_pct, input bit seq);
    int sent  = 0;
    int guard = 0;
    in_data = seq ? 8'd0 : (8'($urandom) & pmask());
    while (sent < n && guard < n * 40 + 200) begin
      in_vld  = ($urandom_range(0, 99) < vld_pct);
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk); mon_step();
      @(posedge clk); #1;
      guard++;
      if (last_acc) begin
        sent++;
        in_data = seq ? 8'(sent) : (8'($urandom) & pmask());
      end
    end
    if (sent < n) check_eq("stream_timeout", 72'(sent), 72'(n));
    in_vld = 1'b0;
  endtask

  task automatic drain();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (4) cyc();
  endtask

  // Select an instance and abort with a pixel presented during clr (must be dropped).
  task automatic switch_cfg(input int s, input int w, input int h, input int k, input int st, input int pw);
    sel = s; cw = w; ch = h; ck = k; cs = st; cpw = pw;
    clr = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
    cyc();
    clr = 1'b0; in_vld = 1'b0;
    cyc();
  endtask

  initial begin
    int          w0, f0;
    logic [71:0] e;
    @(posedge clk); #1;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic 4x4 stream of 0..15
    w0 = win_cnt; f0 = fd_cnt;
    stream(16, 100, 100, 1'b1);
    repeat (3) cyc();
    check_eq("basic_count", 72'(win_cnt - w0), 72'(nwin(4, 4, 3, 1)));
    check_eq("basic_first_idx", 72'(first_idx), 72'(10));
    e = '0;
    for (int k = 0; k < 9; k++) e = e | (72'((k / 3) * 4 + k % 3) << (k * 8));
    check_eq("basic_first_win", first_win, e);
    check_eq("basic_fd_count", 72'(fd_cnt - f0), 72'(1));

    // Two back-to-back frames without a gap
    w0 = win_cnt; f0 = fd_cnt;
    stream(32, 100, 100, 1'b1);
    repeat (3) cyc();
    check_eq("b2b_count", 72'(win_cnt - w0), 72'(2 * nwin(4, 4, 3, 1)));
    check_eq("b2b_fd_count", 72'(fd_cnt - f0), 72'(2));
    check_eq("b2b_fd_gap", 72'(fd_last - fd_prev), 72'(16));

    // Random back-pressure at 30% ready, gappy input
    w0 = win_cnt; f0 = fd_cnt;
    stream(48, 80, 30, 1'b0);
    drain();
    check_eq("bp_count", 72'(win_cnt - w0), 72'(3 * nwin(4, 4, 3, 1)));
    check_eq("bp_q_empty", 72'(exp_q.size()), 72'(0));
    check_eq("bp_fd_count", 72'(fd_cnt - f0), 72'(3));

    // Synchronous reset while stalled with a valid window
    stream(11, 100, 0, 1'b0);
    out_rdy = 1'b0;
    cyc();
    check_eq("hold_vld", 72'(out_vld_m), 72'(1));
    rst_n = 1'b0;
    @(negedge clk); mon_step();
    check_eq("pre_edge_vld", 72'(out_vld_m), 72'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; out_rdy = 1'b1;
    check_eq("post_edge_vld", 72'(out_vld_m), 72'(0));
    cyc();

    // 28x28 stride 2, one bit per pixel
    switch_cfg(1, 28, 28, 3, 2, 1);
    w0 = win_cnt; f0 = fd_cnt;
    stream(784, 100, 100, 1'b0);
    repeat (3) cyc();
    check_eq("s2_count", 72'(win_cnt - w0), 72'(nwin(28, 28, 3, 2)));
    check_eq("s2_fd_count", 72'(fd_cnt - f0), 72'(1));

    // Mid-frame abort after 50 pixels, then a full frame under back-pressure
    stream(50, 100, 100, 1'b0);
    clr = 1'b1; in_vld = 1'b1;
    cyc();
    clr = 1'b0; in_vld = 1'b0;
    w0 = win_cnt;
    stream(784, 90, 70, 1'b0);
    drain();
    check_eq("abort_count", 72'(win_cnt - w0), 72'(nwin(28, 28, 3, 2)));
    check_eq("abort_first_idx", 72'(first_idx), 72'(2 * 28 + 2));
    check_eq("abort_q_empty", 72'(exp_q.size()), 72'(0));

    // Non-square 7x5, K=2, stride 3, 4-bit pixels
    switch_cfg(2, 7, 5, 2, 3, 4);
    w0 = win_cnt; f0 = fd_cnt;
    stream(70, 70, 50, 1'b0);
    drain();
    check_eq("c_count", 72'(win_cnt - w0), 72'(2 * nwin(7, 5, 2, 3)));
    check_eq("c_fd_count", 72'(fd_cnt - f0), 72'(2));
    check_eq("c_q_empty", 72'(exp_q.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_window_gen.md
# cnn_window_gen

Parametrised sliding-window generator for the CNN input path. Accepts a raster-order pixel stream of configurable width and emits every K×K window of an IMG_W×IMG_H frame, with configurable stride. Windows are emitted flattened through a valid/ready output. The block sits between the UART byte unpacker and `cnn_core`, replacing fixed 3×3, 28-wide, 1-bit address sequencing with on-chip line buffers and back-pressure.

## Interface
- `PIX_W`, 1: bits per pixel.
- `IMG_W`, 28: pixels per row, at least K.
- `IMG_H`, 28: rows per frame, at least K.
- `K`, 3: window edge, at least 2.
- `STRIDE`, 1: horizontal and vertical step, at least 1.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `clr`  in  1: synchronous frame abort. Same effect as reset on counters and valid flags; buffer contents are don't-care.
- `in_vld`  in  1: input pixel valid.
- `in_data`  in  PIX_W: input pixel.
- `in_rdy`  out  1: block can accept a pixel.
- `out_vld`  out  1: window valid.
- `out_win`  out  K*K*PIX_W: window data. Element (r,c) is at bits [(r*K+c)*PIX_W +: PIX_W]. r=0 is the oldest (top) row; c=0 is the leftmost column.
- `out_rdy`  in  1: downstream accepts the window.
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Transfers:
  - Input transfer = `in_vld && in_rdy`.
  - Output transfer = `out_vld && out_rdy`.
  - `in_rdy = !out_vld || out_rdy` (combinational). It is forced to 0 while `rst_n` = 0 or `clr` = 1.
- Counters:
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. They advance once per input transfer.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_W-1, IMG_H-1), both wrap to 0 and `frame_done` pulses the next cycle.
- Storage:
  - K-1 line buffers of IMG_W entries each, holding the previous K-1 rows.
  - A K×K shift-register window. Each input transfer shifts the columns left and loads the new right column, built from line-buffer rows (oldest first) plus `in_data`.
- A window is emitted after the pixel at (row, col) when all of these hold:
  - row ≥ K-1 and col ≥ K-1;
  - (row-(K-1)) mod STRIDE == 0;
  - (col-(K-1)) mod STRIDE == 0.
  - Modulo is implemented with phase counters, not dividers.
- Windows per frame = ((IMG_W-K)/STRIDE+1) × ((IMG_H-K)/STRIDE+1), using integer division. Rows and columns beyond the last full stride step produce no window.
- No window ever spans a row boundary: windows are qualified only on col ≥ K-1, so stale columns from the previous row are never emitted.
- Output register:
  - `out_vld` is set on a qualifying input transfer and cleared on an output transfer without a new qualifying input.
  - Simultaneous output transfer and qualifying input: `out_vld` stays 1 and `out_win` updates.
- Priority: `rst_n` low > `clr` > transfers. A pixel presented during `clr` is dropped.
- Reset or `clr` mid-frame:
  - `row`, `col` and phase counters go to 0; `out_vld` and `frame_done` go to 0.
  - The next accepted pixel is (0,0) of a new frame.
  - No window from the aborted frame is emitted afterwards.

## Timing
- Reset values: `out_vld` = 0, `out_win` = 0, `frame_done` = 0, `in_rdy` = 0 during reset and 1 on the first cycle after.
- Latency: qualifying input transfer at edge t → `out_vld` = 1 with the window from cycle t+1.
- Throughput: one pixel per cycle while `out_rdy` is held high; no bubbles at row or frame boundaries.
- Back-pressure: with `out_vld` = 1 and `out_rdy` = 0, `in_rdy` = 0 and `out_win` is held stable.
- `frame_done` is asserted exactly one cycle, in the cycle after the final pixel's transfer, independent of `out_rdy`.
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted in the same cycle `frame_done` is high.

## Test plan
- Basic 3×3 window, IMG_W=IMG_H=4, K=3, STRIDE=1, PIX_W=8:
  - Stimulus: stream 0..15 with `out_rdy`=1.
  - Required: exactly 4 windows, at inputs 10, 11, 14 and 15.
  - First window: {0,1,2,4,5,6,8,9,10} in (r,c) order.
  - `frame_done` pulses one cycle after pixel 15.
- Stride 2, default 28×28, PIX_W=1, STRIDE=2:
  - Stimulus: random bits.
  - Required: 169 windows, each matching a reference model at origins (2i, 2j), i,j < 13.
- Back-pressure:
  - Stimulus: toggle `out_rdy` randomly with a 30% duty cycle.
  - Required: `out_win` stable while stalled, no window lost or duplicated, and in_rdy == (!out_vld || out_rdy) every cycle.
- Mid-frame abort:
  - Stimulus: assert `clr` after 50 pixels of a 28×28 frame, then stream a full frame.
  - Required: exactly 676 windows, all matching the new frame; the first window appears after new pixel index 58.
- Synchronous reset:
  - Stimulus: drop `rst_n` for 1 cycle while `out_vld`=1 and `out_rdy`=0.
  - Required: `out_vld`=0 on the next edge, and no reset effect before that edge.
- Back-to-back frames:
  - Stimulus: two 4×4 frames with no gap.
  - Required: 8 windows total and two `frame_done` pulses 16 cycles apart.
